match_controller: RTL and testbench
===================================

// Module: match_controller
// PURPOSE
//  Parametrised round/match referee for the N-player fighter; next generation of health_status.
//  Tracks per-player health, blocked hits and round wins, and runs the round countdown timer.
//  Sequences the phases IDLE/INTRO/FIGHT/ROUND_END/MATCH_END. Sits between HitDetect and player/rom.
//  Drives controls_enable to the player instances and phase/timer/health to the sprite/HUD path.
// PARAMETERS
//  NUM_PLAYERS    2    number of players, 2..15
//  HEALTH_W       3    health field width per player
//  MAX_HEALTH     5    health restored at every round start, < 2**HEALTH_W
//  ROUNDS_TO_WIN  2    round wins that end the match, 1..15
//  ROUND_TIME     99   round length in seconds, 1..127
//  TICKS_PER_SEC  60   frame_tick pulses per timer second
//  INTRO_FRAMES   120  frame_ticks spent in INTRO
//  END_FRAMES     180  frame_ticks spent in ROUND_END
// PORTS
//  clk            in   1                    system clock (effective_clk)
//  rst            in   1                    synchronous active-high reset
//  frame_tick     in   1                    one-cycle pulse per video frame
//  start          in   1                    level/pulse; begins a match from IDLE or MATCH_END
//  hit_valid      in   NUM_PLAYERS          bit i: player i struck this cycle
//  blocked        in   NUM_PLAYERS          bit i: player i's hit was blocked (qualifies hit_valid)
//  health         out  NUM_PLAYERS*HEALTH_W player i at [i*HEALTH_W +: HEALTH_W]
//  round_wins     out  NUM_PLAYERS*4        player i at [i*4 +: 4]
//  phase          out  3                    0 IDLE, 1 INTRO, 2 FIGHT, 3 ROUND_END, 4 MATCH_END
//  timer          out  7                    seconds remaining in round
//  round_num      out  4                    current round, 1-based, saturates at 15
//  round_winner   out  4                    index of last round winner; 4'hF = none/draw
//  match_winner   out  4                    index of match winner; 4'hF until decided
//  controls_enable out 1                    high only in FIGHT
// BEHAVIOUR
//  Reset values:
//   - phase=IDLE; every health=MAX_HEALTH; round_wins=0; timer=ROUND_TIME.
//   - round_num=0; round_winner=match_winner=4'hF; internal frame/sec counters=0.
//  All outputs are registered. controls_enable is combinational from phase (phase==FIGHT).
//  IDLE: start=1 -> INTRO at next edge. Entering INTRO from IDLE/MATCH_END:
//   - clear wins; round_num=1; match_winner=4'hF.
//  INTRO: counts frame_ticks; on the INTRO_FRAMES-th tick -> FIGHT.
//   - On entry: health=MAX_HEALTH, timer=ROUND_TIME, counters cleared.
//  FIGHT damage:
//   - health_next[i] = health[i]-1 when hit_valid[i] & ~blocked[i], else unchanged; saturates at 0.
//   - Simultaneous hits on several players all apply in the same cycle.
//   - hit_valid is ignored outside FIGHT; blocked hits never change health.
//  FIGHT timer:
//   - sec counter increments per frame_tick.
//   - At TICKS_PER_SEC-1 with a tick: sec counter clears and timer decrements; timer never wraps below 0.
//  FIGHT end check, every cycle, on health_next and registered timer:
//   - KO: at most one player has health_next>0. Winner = that player, or 4'hF if none (double KO).
//   - TIMEOUT: timer==0. Winner = unique player with max health_next; tie -> 4'hF.
//   - KO and TIMEOUT in the same cycle: KO rules apply.
//   - At that same edge: phase=ROUND_END, health=health_next, round_winner set.
//   - Winner's round_wins += 1 (saturate at 15); a draw awards nothing.
//  ROUND_END: holds health/timer; counts END_FRAMES ticks, then:
//   - any round_wins==ROUNDS_TO_WIN -> MATCH_END with match_winner = that index;
//   - else -> INTRO with round_num += 1 (saturate at 15).
//  MATCH_END: all outputs frozen; start=1 -> INTRO (new match). No timeout exit.
//  frame_tick and start sampled only in the phases above; start ignored in INTRO/FIGHT/ROUND_END.
//  rst in any phase, including mid-round, restores the reset values at the next edge.
//  Latency: hit_valid cycle N -> health updated at edge N+1; KO phase change at the same edge.
// TESTING
//  1 rst, start pulse -> INTRO. 120 ticks -> FIGHT, timer=99, all health=5, controls_enable=1.
//  2 Five unblocked hits on P1, 1 per cycle. Health 4,3,2,1,0; 5th edge -> ROUND_END, round_winner=1.
//     Then P2 wins=1; hit_valid with blocked=1 leaves health unchanged.
//  3 Both players at health 1, simultaneous unblocked hits -> ROUND_END, round_winner=F, wins unchanged.
//  4 ROUND_TIME=3, TICKS_PER_SEC=2, no hits -> timer 3,2,1,0 every 2 ticks; tie -> winner F.
//     Repeat with P2 at health 4 -> winner 0.
//  5 P0 wins two rounds -> MATCH_END, match_winner=0, round_num=2; start -> INTRO, wins 0, round_num=1.
//  6 rst asserted mid-FIGHT with health 2/3 -> next edge phase=0, health 5/5, timer 99, winners F.

Source files
------------

// File: rtl/match_controller.sv
// Round/match referee for the N-player fighter: per-player health, round wins,
// round countdown timer and the IDLE/INTRO/FIGHT/ROUND_END/MATCH_END sequence.
module match_controller #(
    parameter int NUM_PLAYERS   = 2,
    parameter int HEALTH_W      = 3,
    parameter int MAX_HEALTH    = 5,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int ROUND_TIME    = 99,
    parameter int TICKS_PER_SEC = 60,
    parameter int INTRO_FRAMES  = 120,
    parameter int END_FRAMES    = 180
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame_tick,
    input  logic                            start,
    input  logic [NUM_PLAYERS-1:0]          hit_valid,
    input  logic [NUM_PLAYERS-1:0]          blocked,
    output logic [NUM_PLAYERS*HEALTH_W-1:0] health,
    output logic [NUM_PLAYERS*4-1:0]        round_wins,
    output logic [2:0]                      phase,
    output logic [6:0]                      timer,
    output logic [3:0]                      round_num,
    output logic [3:0]                      round_winner,
    output logic [3:0]                      match_winner,
    output logic                            controls_enable
);

    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_INTRO     = 3'd1,
        PH_FIGHT     = 3'd2,
        PH_ROUND_END = 3'd3,
        PH_MATCH_END = 3'd4
    } phase_e;

    localparam int FRAME_MAX = (INTRO_FRAMES > END_FRAMES) ? INTRO_FRAMES : END_FRAMES;
    localparam int FRAME_W   = $clog2(FRAME_MAX + 1);
    localparam int SEC_W     = $clog2(TICKS_PER_SEC + 1);
    localparam logic [3:0] NO_PLAYER = 4'hF;

    phase_e              phase_q, phase_d;
    logic [HEALTH_W-1:0] health_q  [NUM_PLAYERS];
    logic [HEALTH_W-1:0] health_d  [NUM_PLAYERS];
    logic [HEALTH_W-1:0] health_nx [NUM_PLAYERS];
    logic [3:0]          wins_q    [NUM_PLAYERS];
    logic [3:0]          wins_d    [NUM_PLAYERS];
    logic [6:0]          timer_q, timer_d;
    logic [3:0]          round_num_q, round_num_d;
    logic [3:0]          round_winner_q, round_winner_d;
    logic [3:0]          match_winner_q, match_winner_d;
    logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [SEC_W-1:0]    sec_cnt_q, sec_cnt_d;

    logic [4:0]          alive_cnt;
    logic [3:0]          alive_idx;
    logic [3:0]          to_winner;
    logic [3:0]          round_result;
    logic [3:0]          champ_idx;
    logic [HEALTH_W-1:0] max_h;
    logic                max_tie;
    logic                round_over;
    logic                champ_found;
    logic                enter_intro;
    logic                new_match;

    // Post-hit health and end-of-round arbitration; only consumed in FIGHT.
    always_comb begin
        alive_cnt = '0;
        alive_idx = NO_PLAYER;
        max_h     = '0;
        to_winner = NO_PLAYER;
        max_tie   = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (hit_valid[i] && !blocked[i] && (health_q[i] != '0)) begin
                health_nx[i] = health_q[i] - HEALTH_W'(1);
            end else begin
                health_nx[i] = health_q[i];
            end
            if (health_nx[i] != '0) begin
                alive_cnt = alive_cnt + 5'd1;
                alive_idx = 4'(i);
            end
            if ((i == 0) || (health_nx[i] > max_h)) begin
                max_h     = health_nx[i];
                to_winner = 4'(i);
                max_tie   = 1'b0;
            end else if (health_nx[i] == max_h) begin
                max_tie = 1'b1;
            end
        end
        // KO takes precedence over a timeout landing in the same cycle.
        if (alive_cnt <= 5'd1) begin
            round_result = (alive_cnt == 5'd1) ? alive_idx : NO_PLAYER;
        end else begin
            round_result = max_tie ? NO_PLAYER : to_winner;
        end
        round_over = (alive_cnt <= 5'd1) || (timer_q == '0);
    end

    always_comb begin
        champ_found = 1'b0;
        champ_idx   = NO_PLAYER;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (wins_q[i] == 4'(ROUNDS_TO_WIN)) begin
                champ_found = 1'b1;
                champ_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        phase_d        = phase_q;
        health_d       = health_q;
        wins_d         = wins_q;
        timer_d        = timer_q;
        round_num_d    = round_num_q;
        round_winner_d = round_winner_q;
        match_winner_d = match_winner_q;
        frame_cnt_d    = frame_cnt_q;
        sec_cnt_d      = sec_cnt_q;
        enter_intro    = 1'b0;
        new_match      = 1'b0;

        case (phase_q)
            PH_IDLE, PH_MATCH_END: begin
                if (start) begin
                    enter_intro = 1'b1;
                    new_match   = 1'b1;
                end
            end
            PH_INTRO: begin
                if (frame_tick) begin
                    if (frame_cnt_q == FRAME_W'(INTRO_FRAMES - 1)) begin
                        phase_d     = PH_FIGHT;
                        frame_cnt_d = '0;
                        sec_cnt_d   = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                    end
                end
            end
            PH_FIGHT: begin
                health_d = health_nx;
                if (round_over) begin
                    phase_d        = PH_ROUND_END;
                    frame_cnt_d    = '0;
                    sec_cnt_d      = '0;
                    round_winner_d = round_result;
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if ((round_result == 4'(i)) && (wins_q[i] != 4'hF)) begin
                            wins_d[i] = wins_q[i] + 4'd1;
                        end
                    end
                end else if (frame_tick) begin
                    if (sec_cnt_q == SEC_W'(TICKS_PER_SEC - 1)) begin
                        sec_cnt_d = '0;
                        if (timer_q != '0) begin
                            timer_d = timer_q - 7'd1;
                        end
                    end else begin
                        sec_cnt_d = sec_cnt_q + SEC_W'(1);
                    end
                end
            end
            PH_ROUND_END: begin
                if (frame_tick) begin
                    if (frame_cnt_q == FRAME_W'(END_FRAMES - 1)) begin
                        frame_cnt_d = '0;
                        if (champ_found) begin
                            phase_d        = PH_MATCH_END;
                            match_winner_d = champ_idx;
                        end else begin
                            enter_intro = 1'b1;
                            round_num_d = (round_num_q == 4'hF) ? 4'hF : round_num_q + 4'd1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                    end
                end
            end
            default: phase_d = PH_IDLE;
        endcase

        if (new_match) begin
            wins_d         = '{default: 4'd0};
            round_num_d    = 4'd1;
            match_winner_d = NO_PLAYER;
        end
        // Every round starts from full health and a full clock.
        if (enter_intro) begin
            phase_d     = PH_INTRO;
            health_d    = '{default: HEALTH_W'(MAX_HEALTH)};
            timer_d     = 7'(ROUND_TIME);
            frame_cnt_d = '0;
            sec_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q        <= PH_IDLE;
            health_q       <= '{default: HEALTH_W'(MAX_HEALTH)};
            wins_q         <= '{default: 4'd0};
            timer_q        <= 7'(ROUND_TIME);
            round_num_q    <= 4'd0;
            round_winner_q <= NO_PLAYER;
            match_winner_q <= NO_PLAYER;
            frame_cnt_q    <= '0;
            sec_cnt_q      <= '0;
        end else begin
            phase_q        <= phase_d;
            health_q       <= health_d;
            wins_q         <= wins_d;
            timer_q        <= timer_d;
            round_num_q    <= round_num_d;
            round_winner_q <= round_winner_d;
            match_winner_q <= match_winner_d;
            frame_cnt_q    <= frame_cnt_d;
            sec_cnt_q      <= sec_cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
        assign health[g*HEALTH_W +: HEALTH_W] = health_q[g];
        assign round_wins[g*4 +: 4]           = wins_q[g];
    end

    assign phase           = phase_q;
    assign timer           = timer_q;
    assign round_num       = round_num_q;
    assign round_winner    = round_winner_q;
    assign match_winner    = match_winner_q;
    assign controls_enable = (phase_q == PH_FIGHT);

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: a default-parameter instance for KO/round flow and
// a short-timer instance for timeout and full-match sequencing.
module tb_match_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [1:0] hit_valid = 2'b00;
    logic [1:0] blocked = 2'b00;
    logic [5:0] health;
    logic [7:0] round_wins;
    logic [2:0] phase;
    logic [6:0] timer;
    logic [3:0] round_num, round_winner, match_winner;
    logic       controls_enable;

    logic       t_tick = 1'b0;
    logic       t_start = 1'b0;
    logic [1:0] t_hit = 2'b00;
    logic [1:0] t_blk = 2'b00;
    logic [5:0] t_health;
    logic [7:0] t_wins;
    logic [2:0] t_phase;
    logic [6:0] t_timer;
    logic [3:0] t_round_num, t_round_winner, t_match_winner;
    logic       t_ce;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    always #5 clk = ~clk;

    match_controller dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .hit_valid(hit_valid), .blocked(blocked), .health(health),
        .round_wins(round_wins), .phase(phase), .timer(timer),
        .round_num(round_num), .round_winner(round_winner),
        .match_winner(match_winner), .controls_enable(controls_enable)
    );

    match_controller #(
        .ROUND_TIME(3), .TICKS_PER_SEC(2), .INTRO_FRAMES(4), .END_FRAMES(4)
    ) dut_t (
        .clk(clk), .rst(rst), .frame_tick(t_tick), .start(t_start),
        .hit_valid(t_hit), .blocked(t_blk), .health(t_health),
        .round_wins(t_wins), .phase(t_phase), .timer(t_timer),
        .round_num(t_round_num), .round_winner(t_round_winner),
        .match_winner(t_match_winner), .controls_enable(t_ce)
    );

    function automatic logic [7:0] hp(input int p0, input int p1);
        logic [2:0] a;
        logic [2:0] b;
        a = p0[2:0];
        b = p1[2:0];
        return {2'b00, b, a};
    endfunction

    // Driver tasks: inputs change just after the falling edge, outputs are read there too.
    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic t_tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            t_tick = 1'b1;
            @(negedge clk);
        end
        t_tick = 1'b0;
    endtask

    task automatic hit_cycle(input logic [1:0] hv, input logic [1:0] bk);
        hit_valid = hv;
        blocked = bk;
        @(negedge clk);
        hit_valid = 2'b00;
        blocked = 2'b00;
    endtask

    task automatic t_hit_cycle(input logic [1:0] hv);
        t_hit = hv;
        @(negedge clk);
        t_hit = 2'b00;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++; if (phase !== 3'd0) begin bad++; $display("FAIL rst_phase got=%0d want=0", phase); end
        total++; if (health !== 6'b101101) begin bad++; $display("FAIL rst_health got=%b want=101101", health); end
        total++; if (round_wins !== 8'h00) begin bad++; $display("FAIL rst_wins got=%h want=00", round_wins); end
        total++; if (timer !== 7'd99) begin bad++; $display("FAIL rst_timer got=%0d want=99", timer); end
        total++; if (round_num !== 4'd0) begin bad++; $display("FAIL rst_round_num got=%0d want=0", round_num); end
        total++; if (round_winner !== 4'hF) begin bad++; $display("FAIL rst_round_winner got=%h want=f", round_winner); end
        total++; if (match_winner !== 4'hF) begin bad++; $display("FAIL rst_match_winner got=%h want=f", match_winner); end
        total++; if (controls_enable !== 1'b0) begin bad++; $display("FAIL rst_ce got=%b want=0", controls_enable); end
        total++; if (t_timer !== 7'd3) begin bad++; $display("FAIL rst_t_timer got=%0d want=3", t_timer); end
    endtask

    task automatic test_intro;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (phase !== 3'd1) begin bad++; $display("FAIL intro_phase got=%0d want=1", phase); end
        total++; if (round_num !== 4'd1) begin bad++; $display("FAIL intro_round got=%0d want=1", round_num); end
        hit_cycle(2'b11, 2'b00);
        total++; if (health !== 6'b101101) begin bad++; $display("FAIL intro_hit_ignored got=%b want=101101", health); end
        tick_n(119);
        total++; if (phase !== 3'd1) begin bad++; $display("FAIL intro_119 got=%0d want=1", phase); end
        tick_n(1);
        total++; if (phase !== 3'd2) begin bad++; $display("FAIL intro_120 got=%0d want=2", phase); end
        total++; if (timer !== 7'd99) begin bad++; $display("FAIL fight_timer got=%0d want=99", timer); end
        total++; if (health !== 6'b101101) begin bad++; $display("FAIL fight_health got=%b want=101101", health); end
        total++; if (controls_enable !== 1'b1) begin bad++; $display("FAIL fight_ce got=%b want=1", controls_enable); end
    endtask

    task automatic test_ko;
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back(hp(5 - k, 5));
            hit_cycle(2'b01, 2'b00);
            exp_v = exp_q.pop_front();
            total++; if ({2'b00, health} !== exp_v) begin bad++; $display("FAIL ko_health_%0d got=%b want=%b", k, health, exp_v[5:0]); end
        end
        total++; if (phase !== 3'd3) begin bad++; $display("FAIL ko_phase got=%0d want=3", phase); end
        total++; if (round_winner !== 4'd1) begin bad++; $display("FAIL ko_winner got=%h want=1", round_winner); end
        total++; if (round_wins !== 8'h10) begin bad++; $display("FAIL ko_wins got=%h want=10", round_wins); end
        total++; if (controls_enable !== 1'b0) begin bad++; $display("FAIL ko_ce got=%b want=0", controls_enable); end
        hit_cycle(2'b10, 2'b00);
        total++; if (health !== 6'b101000) begin bad++; $display("FAIL end_hit_ignored got=%b want=101000", health); end
        tick_n(179);
        total++; if (phase !== 3'd3) begin bad++; $display("FAIL end_179 got=%0d want=3", phase); end
        tick_n(1);
        total++; if (phase !== 3'd1) begin bad++; $display("FAIL end_180 got=%0d want=1", phase); end
        total++; if (round_num !== 4'd2) begin bad++; $display("FAIL round2 got=%0d want=2", round_num); end
        total++; if (health !== 6'b101101) begin bad++; $display("FAIL round2_health got=%b want=101101", health); end
        tick_n(120);
    endtask

    task automatic test_blocked;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (phase !== 3'd2) begin bad++; $display("FAIL fight_start_ignored got=%0d want=2", phase); end
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(hp(5, 5));
            hit_cycle(2'b11, 2'b11);
            exp_v = exp_q.pop_front();
            total++; if ({2'b00, health} !== exp_v) begin bad++; $display("FAIL blocked_%0d got=%b want=%b", k, health, exp_v[5:0]); end
        end
        exp_q.push_back(hp(5, 4));
        hit_cycle(2'b11, 2'b01);
        exp_v = exp_q.pop_front();
        total++; if ({2'b00, health} !== exp_v) begin bad++; $display("FAIL half_blocked got=%b want=%b", health, exp_v[5:0]); end
        exp_q.push_back(hp(4, 3));
        hit_cycle(2'b11, 2'b00);
        exp_v = exp_q.pop_front();
        total++; if ({2'b00, health} !== exp_v) begin bad++; $display("FAIL both_hit got=%b want=%b", health, exp_v[5:0]); end
    endtask

    task automatic test_double_ko;
        for (int k = 0; k < 3; k++) hit_cycle(2'b01, 2'b00);
        for (int k = 0; k < 2; k++) hit_cycle(2'b10, 2'b00);
        total++; if (health !== 6'b001001) begin bad++; $display("FAIL dko_pre got=%b want=001001", health); end
        total++; if (phase !== 3'd2) begin bad++; $display("FAIL dko_pre_phase got=%0d want=2", phase); end
        hit_cycle(2'b11, 2'b00);
        total++; if (phase !== 3'd3) begin bad++; $display("FAIL dko_phase got=%0d want=3", phase); end
        total++; if (health !== 6'b000000) begin bad++; $display("FAIL dko_health got=%b want=000000", health); end
        total++; if (round_winner !== 4'hF) begin bad++; $display("FAIL dko_winner got=%h want=f", round_winner); end
        total++; if (round_wins !== 8'h10) begin bad++; $display("FAIL dko_wins got=%h want=10", round_wins); end
    endtask

    task automatic test_timeout;
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        t_tick_n(4);
        total++; if (t_phase !== 3'd2) begin bad++; $display("FAIL to_fight got=%0d want=2", t_phase); end
        for (int s = 2; s >= 0; s--) begin
            exp_q.push_back(8'(s));
            t_tick_n(2);
            exp_v = exp_q.pop_front();
            total++; if ({1'b0, t_timer} !== exp_v) begin bad++; $display("FAIL to_timer got=%0d want=%0d", t_timer, exp_v); end
        end
        total++; if (t_phase !== 3'd2) begin bad++; $display("FAIL to_zero_phase got=%0d want=2", t_phase); end
        @(negedge clk);
        total++; if (t_phase !== 3'd3) begin bad++; $display("FAIL to_end got=%0d want=3", t_phase); end
        total++; if (t_round_winner !== 4'hF) begin bad++; $display("FAIL to_tie got=%h want=f", t_round_winner); end
        total++; if (t_wins !== 8'h00) begin bad++; $display("FAIL to_tie_wins got=%h want=00", t_wins); end
        t_tick_n(4);
        total++; if (t_round_num !== 4'd2) begin bad++; $display("FAIL to_round2 got=%0d want=2", t_round_num); end
        t_tick_n(4);
        t_hit_cycle(2'b10);
        total++; if (t_health !== 6'b100101) begin bad++; $display("FAIL to_p1_hit got=%b want=100101", t_health); end
        t_tick_n(6);
        @(negedge clk);
        total++; if (t_phase !== 3'd3) begin bad++; $display("FAIL to2_end got=%0d want=3", t_phase); end
        total++; if (t_round_winner !== 4'd0) begin bad++; $display("FAIL to2_winner got=%h want=0", t_round_winner); end
        total++; if (t_wins !== 8'h01) begin bad++; $display("FAIL to2_wins got=%h want=01", t_wins); end
    endtask

    task automatic test_match;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        for (int r = 1; r <= 2; r++) begin
            t_tick_n(4);
            for (int k = 0; k < 5; k++) t_hit_cycle(2'b10);
            exp_q.push_back(8'(r));
            exp_v = exp_q.pop_front();
            total++; if (t_wins !== exp_v) begin bad++; $display("FAIL m_wins_r%0d got=%h want=%h", r, t_wins, exp_v); end
            total++; if (t_phase !== 3'd3) begin bad++; $display("FAIL m_end_r%0d got=%0d want=3", r, t_phase); end
            if (r == 1) t_tick_n(4);
        end
        t_tick_n(3);
        total++; if (t_phase !== 3'd3) begin bad++; $display("FAIL m_end_hold got=%0d want=3", t_phase); end
        t_tick_n(1);
        total++; if (t_phase !== 3'd4) begin bad++; $display("FAIL m_match_end got=%0d want=4", t_phase); end
        total++; if (t_match_winner !== 4'd0) begin bad++; $display("FAIL m_winner got=%h want=0", t_match_winner); end
        total++; if (t_round_num !== 4'd2) begin bad++; $display("FAIL m_round got=%0d want=2", t_round_num); end
        t_hit = 2'b11;
        t_tick_n(5);
        t_hit = 2'b00;
        total++; if (t_phase !== 3'd4) begin bad++; $display("FAIL m_frozen_phase got=%0d want=4", t_phase); end
        total++; if (t_health !== 6'b000101) begin bad++; $display("FAIL m_frozen_health got=%b want=000101", t_health); end
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        total++; if (t_phase !== 3'd1) begin bad++; $display("FAIL m_restart got=%0d want=1", t_phase); end
        total++; if (t_wins !== 8'h00) begin bad++; $display("FAIL m_restart_wins got=%h want=00", t_wins); end
        total++; if (t_round_num !== 4'd1) begin bad++; $display("FAIL m_restart_round got=%0d want=1", t_round_num); end
        total++; if (t_match_winner !== 4'hF) begin bad++; $display("FAIL m_restart_mw got=%h want=f", t_match_winner); end
        t_tick_n(2);
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        t_tick_n(1);
        total++; if (t_phase !== 3'd1) begin bad++; $display("FAIL m_intro_start_ignored got=%0d want=1", t_phase); end
        t_tick_n(1);
        total++; if (t_phase !== 3'd2) begin bad++; $display("FAIL m_intro_done got=%0d want=2", t_phase); end
    endtask

    task automatic test_mid_reset;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tick_n(120);
        tick_n(59);
        total++; if (timer !== 7'd99) begin bad++; $display("FAIL sec_59 got=%0d want=99", timer); end
        tick_n(1);
        total++; if (timer !== 7'd98) begin bad++; $display("FAIL sec_60 got=%0d want=98", timer); end
        hit_cycle(2'b11, 2'b00);
        hit_cycle(2'b11, 2'b00);
        hit_cycle(2'b01, 2'b00);
        total++; if (health !== 6'b011010) begin bad++; $display("FAIL mid_health got=%b want=011010", health); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (phase !== 3'd0) begin bad++; $display("FAIL mid_rst_phase got=%0d want=0", phase); end
        total++; if (health !== 6'b101101) begin bad++; $display("FAIL mid_rst_health got=%b want=101101", health); end
        total++; if (timer !== 7'd99) begin bad++; $display("FAIL mid_rst_timer got=%0d want=99", timer); end
        total++; if (round_winner !== 4'hF) begin bad++; $display("FAIL mid_rst_rw got=%h want=f", round_winner); end
        total++; if (match_winner !== 4'hF) begin bad++; $display("FAIL mid_rst_mw got=%h want=f", match_winner); end
        total++; if (round_num !== 4'd0) begin bad++; $display("FAIL mid_rst_round got=%0d want=0", round_num); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_intro;
        test_ko;
        test_blocked;
        test_double_ko;
        test_timeout;
        test_match;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
